// File: rtl/scaler_stream_pkg.sv
// Shared types and defaults for the scaler pixel-stream blocks.
//
// Contents:
//   DIM_WIDTH_DEF  - default width of frame-geometry inputs and x/y counters
//   DATA_WIDTH_DEF - default gray pixel width
//   state_t        - frame sequencer states {IDLE, RUN, DRAIN, DONE}
//   beat_t         - one stream beat {data, sof, eol} at the default pixel width
//
// Optional feature macro used by scaler_stream_src: SCALER_STREAM_SRC_PATTERN_EN.
package scaler_stream_pkg;

  localparam int unsigned DIM_WIDTH_DEF  = 16;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      sof;
    logic                      eol;
  } beat_t;

endpackage

// File: rtl/scaler_skid_buf.sv
// Two-entry registered valid/ready buffer (main + skid) carrying one beat type.
//
// Handshake: a beat moves across a port in every cycle where its valid and
// ready are both high at the rising clock edge. out_valid_o and out_beat_o
// stay stable from assertion until that transfer. in_ready_o is a flop
// output (skid entry empty), so no out_ready_i -> in_ready_o path exists.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   in_valid_i / in_beat_i  write side; a beat is taken when in_ready_o is high
//   in_ready_o              skid entry free
//   out_valid_o/out_beat_o  main entry, drives the consumer
//   out_ready_i             consumer ready
module scaler_skid_buf
  import scaler_stream_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid_i,
  input  T     in_beat_i,
  output logic in_ready_o,
  output logic out_valid_o,
  output T     out_beat_o,
  input  logic out_ready_i
);

  T     main_q, main_d;
  T     skid_q, skid_d;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic out_xfer;
  logic main_free;
  logic push;

  assign out_xfer  = main_vld_q && out_ready_i;
  assign main_free = !main_vld_q || out_xfer;
  assign push      = in_valid_i && !skid_vld_q;

  // The skid entry is always older than an incoming beat, so it refills
  // main first; a push can only happen while skid is empty.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (main_free) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (push) begin
        main_d     = in_beat_i;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (push) begin
      skid_d     = in_beat_i;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign in_ready_o  = !skid_vld_q;
  assign out_valid_o = main_vld_q;
  assign out_beat_o  = main_q;

endmodule

// File: rtl/scaler_stream_src.sv
// Pixel source for the gray scaler input: pops a first-word-fall-through FIFO
// and streams exactly width*height pixels per frame, tagging start-of-frame
// and end-of-line, through a registered 2-entry skid buffer.
//
// Ports:
//   clk_i, rst_i                clock, asynchronous active-low reset
//   frame_start_i               start pulse, accepted only in IDLE
//   src_width_i, src_height_i   geometry, latched on an accepted start
//   fifo_empty_i, fifo_data_i   FWFT FIFO head
//   fifo_rd_o                   FIFO pop strobe
//   tvalid_o, tdata_o, tready_i pixel stream to the scaler
//   sof_o, eol_o                first pixel of frame / last pixel of line
//   busy_o                      high in RUN, DRAIN and DONE
//   frame_done_o                one-cycle pulse after the last pixel transfers
//   state_o                     sequencer state, debug visibility
//   pattern_sel_i               only with SCALER_STREAM_SRC_PATTERN_EN: latched
//                               at frame start, replaces FIFO data by (x+y)
//
// Handshake: a pixel transfers when tvalid_o && tready_i at the rising edge;
// tvalid_o, tdata_o, sof_o and eol_o hold until that transfer.
module scaler_stream_src
  import scaler_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DIM_WIDTH  = DIM_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  frame_start_i,
  input  logic [DIM_WIDTH-1:0]  src_width_i,
  input  logic [DIM_WIDTH-1:0]  src_height_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
`ifdef SCALER_STREAM_SRC_PATTERN_EN
  input  logic                  pattern_sel_i,
`endif
  output logic                  tvalid_o,
  output logic [DATA_WIDTH-1:0] tdata_o,
  input  logic                  tready_i,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output state_t                state_o
);

  // Beat type at this instance's pixel width (package beat_t is the default-width form).
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eol;
  } pix_beat_t;

  state_t                state_q;
  logic [DIM_WIDTH-1:0]  width_q;
  logic [DIM_WIDTH-1:0]  height_q;
  logic [DIM_WIDTH-1:0]  x_q;
  logic [DIM_WIDTH-1:0]  y_q;
  logic                  last_x;
  logic                  last_y;
  logic                  src_ok;
  logic                  skid_free;
  logic                  gen;
  logic                  drained_next;
  logic [DATA_WIDTH-1:0] in_data;
  pix_beat_t             in_beat;
  pix_beat_t             out_beat;

  assign last_x = (x_q == width_q - DIM_WIDTH'(1));
  assign last_y = (y_q == height_q - DIM_WIDTH'(1));

`ifdef SCALER_STREAM_SRC_PATTERN_EN
  logic pat_q;
  assign src_ok    = pat_q ? 1'b1 : !fifo_empty_i;
  assign fifo_rd_o = gen && !pat_q;
  assign in_data   = pat_q ? DATA_WIDTH'(x_q + y_q) : fifo_data_i;
`else
  assign src_ok    = !fifo_empty_i;
  assign fifo_rd_o = gen;
  assign in_data   = fifo_data_i;
`endif

  // Pop decision depends on flops and the FIFO flag only, never on tready_i.
  assign gen = (state_q == RUN) && src_ok && skid_free;

  // Nothing is written while draining, so the buffer is empty next cycle
  // when skid is free and main is empty or handing off its beat now.
  assign drained_next = skid_free && (!tvalid_o || tready_i);

  always_comb begin
    in_beat      = '0;
    in_beat.data = in_data;
    in_beat.sof  = (x_q == '0) && (y_q == '0);
    in_beat.eol  = last_x;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
`ifdef SCALER_STREAM_SRC_PATTERN_EN
      pat_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start_i) begin
            width_q  <= src_width_i;
            height_q <= src_height_i;
            x_q      <= '0;
            y_q      <= '0;
`ifdef SCALER_STREAM_SRC_PATTERN_EN
            pat_q    <= pattern_sel_i;
`endif
            state_q  <= ((src_width_i == '0) || (src_height_i == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (gen) begin
            if (last_x) begin
              x_q <= '0;
              if (last_y) begin
                state_q <= DRAIN;
              end else begin
                y_q <= y_q + DIM_WIDTH'(1);
              end
            end else begin
              x_q <= x_q + DIM_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (drained_next) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  scaler_skid_buf #(
    .T (pix_beat_t)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (gen),
    .in_beat_i   (in_beat),
    .in_ready_o  (skid_free),
    .out_valid_o (tvalid_o),
    .out_beat_o  (out_beat),
    .out_ready_i (tready_i)
  );

  assign tdata_o      = out_beat.data;
  assign sof_o        = out_beat.sof;
  assign eol_o        = out_beat.eol;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = (state_q == DONE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_scaler_stream_src.sv
// Directed-sequence bench for scaler_stream_src with randomized data and
// backpressure. A FIFO model feeds the DUT; each frame's expected beats are
// built from the geometry (data in pop order, sof on pixel 0, eol where
// index mod width == width-1) and checked at every transfer.
module tb_scaler_stream_src;
  import scaler_stream_pkg::*;

  localparam int DW = 8;
  localparam int MW = 16;
  localparam int BW = DW + 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          frame_start = 1'b0;
  logic [MW-1:0] src_w = '0;
  logic [MW-1:0] src_h = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tready = 1'b0;
  logic          sof;
  logic          eol;
  logic          busy;
  logic          frame_done;
  state_t        state;

  scaler_stream_src #(
    .DATA_WIDTH (DW),
    .DIM_WIDTH  (MW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .frame_start_i(frame_start),
    .src_width_i  (src_w),
    .src_height_i (src_h),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_rd_o    (fifo_rd),
    .tvalid_o     (tvalid),
    .tdata_o      (tdata),
    .tready_i     (tready),
    .sof_o        (sof),
    .eol_o        (eol),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .state_o      (state)
  );

  // Scoreboard
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] fifo_q[$];
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_tvalid"}, 32'(tvalid), 32'd0);
    check({nm, "_tdata"}, 32'(tdata), 32'd0);
    check({nm, "_sof"}, 32'(sof), 32'd0);
    check({nm, "_eol"}, 32'(eol), 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_done"}, 32'(frame_done), 32'd0);
    check({nm, "_rd"}, 32'(fifo_rd), 32'd0);
    check({nm, "_state"}, 32'(state), 32'(IDLE));
  endtask

  // Driver: one frame. Entered just after a falling edge, returns just after one.
  // mode: 0 ready always, 1 ready 1,0,0,1 repeating, 2 random, 3 never ready.
  task automatic run_frame(input string nm, input int w, input int h, input int mode,
                           input int gap_after, input int gap_len, input int restart_at,
                           input bit start_in_done, input bit abort, input int extra,
                           input bit rnd);
    int total, pops, xfers, gap_cnt, cyc, outstanding;
    bit finished, aborted, last_xfer_prev, prev_stall, prev_rd, gap, xfer, exp_done;
    logic [BW-1:0] prev_beat, exp_beat;
    logic [DW-1:0] v;
    fifo_q.delete();
    exp_q.delete();
    total = w * h;
    for (int i = 0; i < total; i++) begin
      v = rnd ? DW'($urandom_range(0, 255)) : DW'(i);
      fifo_q.push_back(v);
      exp_q.push_back({v, (i == 0), ((i % w) == (w - 1))});
    end
    for (int i = 0; i < extra; i++) fifo_q.push_back(DW'($urandom_range(0, 255)));
    pops = 0; xfers = 0; gap_cnt = 0; cyc = 0;
    finished = 0; aborted = 0; last_xfer_prev = 0; prev_stall = 0; prev_rd = 0;
    prev_beat = '0;

    frame_start = 1'b1;
    src_w = MW'(w);
    src_h = MW'(h);
    tready = 1'b1;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    @(negedge clk);
    frame_start = 1'b0;

    while (!finished && !aborted && cyc < 400) begin
      gap = (pops == gap_after) && (gap_cnt < gap_len);
      if (gap) gap_cnt++;
      fifo_empty = gap || (fifo_q.size() == 0);
      fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
      case (mode)
        0: tready = 1'b1;
        1: tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2: tready = 1'($urandom_range(0, 1));
        default: tready = 1'b0;
      endcase
      frame_start = (cyc == restart_at) || (start_in_done && last_xfer_prev);
      src_w = MW'($urandom_range(1, 9));
      src_h = MW'($urandom_range(1, 9));
      #1;
      outstanding = pops - xfers;
      if (abort && outstanding == 2) begin
        check({nm, "_pre_abort_valid"}, 32'(tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero({nm, "_abort"});
        aborted = 1;
      end else begin
        if (fifo_rd) begin
          check({nm, "_rd_skid_full"}, 32'(outstanding < 2), 32'd1);
          check({nm, "_rd_fifo_empty"}, 32'(fifo_empty), 32'd0);
          check({nm, "_rd_past_frame"}, 32'(pops < total), 32'd1);
          if (fifo_q.size() != 0) v = fifo_q.pop_front();
          pops++;
        end
        if (mode == 0) check({nm, "_latency"}, 32'(tvalid), 32'(prev_rd));
        if (prev_stall) begin
          check({nm, "_hold_valid"}, 32'(tvalid), 32'd1);
          check({nm, "_hold_beat"}, 32'({tdata, sof, eol}), 32'(prev_beat));
        end
        xfer = tvalid && tready;
        if (xfer) begin
          check({nm, "_beat_expected"}, 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_beat = exp_q.pop_front();
            check({nm, "_beat"}, 32'({tdata, sof, eol}), 32'(exp_beat));
          end
          xfers++;
        end
        exp_done = (total == 0) ? (cyc == 0) : last_xfer_prev;
        check({nm, "_frame_done"}, 32'(frame_done), 32'(exp_done));
        check({nm, "_busy"}, 32'(busy), 32'd1);
        finished = frame_done || exp_done;
        last_xfer_prev = xfer && (xfers == total);
        prev_stall = tvalid && !tready;
        prev_beat = {tdata, sof, eol};
        prev_rd = fifo_rd;
      end
      @(negedge clk);
      cyc++;
    end
    frame_start = 1'b0;

    if (aborted) begin
      rst_n = 1'b1;
    end else begin
      check({nm, "_finished"}, 32'(finished), 32'd1);
      for (int k = 0; k < 3; k++) begin
        fifo_empty = (fifo_q.size() == 0);
        fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        tready = 1'b1;
        #1;
        check({nm, "_post_busy"}, 32'(busy), 32'd0);
        check({nm, "_post_done"}, 32'(frame_done), 32'd0);
        check({nm, "_post_valid"}, 32'(tvalid), 32'd0);
        check({nm, "_post_rd"}, 32'(fifo_rd), 32'd0);
        @(negedge clk);
      end
      check({nm, "_beats_left"}, 32'(exp_q.size()), 32'd0);
      check({nm, "_pops"}, 32'(pops), 32'(total));
      check({nm, "_fifo_left"}, 32'(fifo_q.size()), 32'(extra));
    end
  endtask

  initial begin
    int w, h;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //        name        w  h  mode gap_at gap_len restart in_done abort extra rnd
    run_frame("seq4x2",   4, 2, 0,   -1,    0,      -1,     0,      0,    0,    0);
    run_frame("toggle",   4, 2, 1,   -1,    0,      -1,     0,      0,    0,    0);
    run_frame("fifo_gap", 4, 2, 0,    3,   10,      -1,     0,      0,    0,    0);
    run_frame("zero_w",   0, 5, 0,   -1,    0,      -1,     0,      0,    4,    1);
    run_frame("restart",  4, 2, 0,   -1,    0,       3,     0,      0,    9,    1);
    run_frame("in_done",  3, 3, 2,   -1,    0,      -1,     1,      0,    5,    1);
    run_frame("abort",    4, 2, 3,   -1,    0,      -1,     0,      1,    0,    1);
    run_frame("after_rst",2, 2, 0,   -1,    0,      -1,     0,      0,    0,    1);
    run_frame("width1",   1, 3, 1,   -1,    0,      -1,     0,      0,    0,    1);
    for (int f = 0; f < 6; f++) begin
      w = int'($urandom_range(1, 6));
      h = int'($urandom_range(1, 4));
      run_frame("random", w, h, 2, int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                -1, 0, 0, 2, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scaler_stream_src.md
Name: scaler_stream_src

Overview:
- Transmitter side of the scaler pixel-input handshake (tvalid/tdata/tready).
- Pops gray pixels from an upstream first-word-fall-through FIFO (frame-buffer reader) and emits exactly src_width*src_height pixels per frame.
- Honours scaler backpressure without combinational ready paths, and tags start-of-frame and end-of-line.
- Sits directly in front of the gray scaler input.

Parameters:
- DATA_WIDTH, 8, pixel width; one gray channel.
- DIM_WIDTH, 16, width of frame-geometry inputs and internal x/y counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- frame_start_i  in  1  one-cycle pulse; begin a frame; ignored unless idle.
- src_width_i  in  DIM_WIDTH  pixels per line; latched on accepted frame_start_i.
- src_height_i  in  DIM_WIDTH  lines per frame; latched on accepted frame_start_i.
- fifo_empty_i  in  1  upstream FIFO empty.
- fifo_data_i  in  DATA_WIDTH  FWFT head word; valid when !fifo_empty_i.
- fifo_rd_o  out  1  pop strobe.
- tvalid_o  out  1  pixel valid to scaler.
- tdata_o  out  DATA_WIDTH  pixel.
- tready_i  in  1  scaler ready.
- sof_o  out  1  high with first pixel of frame.
- eol_o  out  1  high with last pixel of each line.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse after last pixel accepted.

Behaviour:
- Reset values: fifo_rd_o=0, tvalid_o=0, tdata_o=0, sof_o=0, eol_o=0, busy_o=0, frame_done_o=0. Counters cleared, state IDLE.
- Asynchronous reset assertion mid-frame aborts the frame immediately. Buffered pixels are discarded. No frame_done_o is issued.
- States:
  - IDLE: frame_start_i latches geometry. If width==0 or height==0, go to DONE; otherwise go to RUN.
  - RUN: pop pixels until W*H popped, then go to DRAIN.
  - DRAIN: wait until both buffer entries are empty, then go to DONE.
  - DONE: frame_done_o=1 for one cycle, then go to IDLE.
- busy_o=1 in RUN, DRAIN and DONE.
- Transfer occurs when tvalid_o && tready_i.
- Output stage is a registered 2-entry skid buffer (main + skid). Each entry carries {data, sof, eol}.
  - fifo_rd_o = RUN && !fifo_empty_i && skid entry empty && pixels remain.
  - The decision uses only registered state, so there is no tready_i to fifo_rd_o combinational path.
  - Popped word is written into main (if empty, or if main transfers this cycle), else into skid.
- Latency: the pixel popped in cycle n is on tvalid_o/tdata_o in cycle n+1.
- Throughput: with tready_i held high and FIFO non-empty, 1 pixel/clk sustained.
- Once asserted, tvalid_o and tdata_o/sof_o/eol_o stay stable until transfer (AXI-Stream rule).
- x counter counts 0..W-1 per pop; y counter counts 0..H-1, incrementing when x wraps.
  - sof = (x==0 && y==0).
  - eol = (x==W-1).
- The pop that makes x==W-1 && y==H-1 is the last pop of the frame.
- frame_done_o is asserted in the cycle after the last pixel's transfer.
- FIFO empty mid-frame: stall popping. tvalid_o falls once buffers drain. No error is raised.
- frame_start_i during RUN, DRAIN or DONE is ignored. Geometry inputs are sampled only on an accepted frame_start_i.
- frame_start_i in the same cycle as DONE is ignored. A new frame may start in the cycle after DONE.

Optional Feature:
- Macro SCALER_STREAM_SRC_PATTERN_EN.
- When defined: adds input pattern_sel_i (1 bit). While pattern_sel_i=1 at frame start (latched), the FIFO is bypassed.
  - fifo_rd_o stays 0.
  - Pixels generate every cycle the skid entry is free.
  - Pixel value = (x+y) truncated to DATA_WIDTH.
- When undefined: port absent; data always comes from the FIFO.

Decomposition:
- Package scaler_stream_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - pixel-beat struct {data, sof, eol};
  - DIM_WIDTH default constant.
- Sub-module scaler_skid_buf: 2-entry registered valid/ready buffer carrying the beat struct. Reusable for the scaler output side.

Test Plan:
- 4x2 frame, FIFO preloaded with 0..7, tready=1:
  - tdata sequence 0..7 on consecutive cycles, first beat 1 cycle after first pop;
  - sof on pixel 0 only;
  - eol on pixels 3 and 7;
  - frame_done_o one cycle after pixel 7 transfers.
- Same frame, tready toggling 1,0,0,1 repeating:
  - no data lost or duplicated;
  - tdata stable while stalled;
  - fifo_rd_o never high while skid full.
- FIFO empty after 3 pixels for 10 cycles, then refilled:
  - tvalid_o drops after pixel 2, resumes with pixel 3;
  - sof/eol positions unchanged.
- frame_start_i with width=0, height=5:
  - no tvalid_o, no fifo_rd_o;
  - busy_o high 1 cycle, frame_done_o pulse.
- Assert rst_i low mid-frame with 2 beats buffered: all outputs go to 0 asynchronously; a subsequent 2x2 frame streams cleanly.
- frame_start_i pulsed during RUN with different geometry: ignored, current frame completes with the original W*H.
